// File: rtl/jtag_tap_responder.sv
// Target-side JTAG TAP (IDCODE, BYPASS, USER DR), with pins oversampled in the clk domain.
// Optional JTAG_TRST_EN adds an asynchronous, active-low trst_n that holds the TAP in TLR.
module jtag_tap_responder #(
  parameter int unsigned IR_LEN      = 4,
  parameter logic [31:0] IDCODE_VAL  = 32'h1485_A0DD,
  parameter int unsigned USER_LEN    = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tck,
  input  logic                tms,
  input  logic                tdi,
`ifdef JTAG_TRST_EN
  input  logic                trst_n,
`endif
  output logic                tdo,
  output logic                tdo_oe,
  input  logic [USER_LEN-1:0] user_rd_data,
  output logic [USER_LEN-1:0] user_wr_data,
  output logic                user_wr_stb,
  output logic [3:0]          tap_state
);

  typedef enum logic [3:0] {
    StTlr     = 4'hF, StRti     = 4'hC, StSelDr   = 4'h7, StCapDr = 4'h6,
    StShDr    = 4'h2, StEx1Dr   = 4'h1, StPauseDr = 4'h3, StEx2Dr = 4'h0,
    StUpdDr   = 4'h5, StSelIr   = 4'h4, StCapIr   = 4'hE, StShIr  = 4'hA,
    StEx1Ir   = 4'h9, StPauseIr = 4'hB, StEx2Ir   = 4'h8, StUpdIr = 4'hD
  } tap_state_e;

  localparam logic [IR_LEN-1:0] IrIdcode = IR_LEN'(1);
  localparam logic [IR_LEN-1:0] IrUser   = IR_LEN'(2);

  logic [SYNC_STAGES-1:0] tck_sync_q, tms_sync_q, tdi_sync_q;
  logic                   tck_prev_q;
  logic                   tck_s, tms_s, tdi_s, rise, fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tck_sync_q <= '0;
      tms_sync_q <= '0;
      tdi_sync_q <= '0;
      tck_prev_q <= 1'b0;
    end else begin
      tck_sync_q <= {tck_sync_q[SYNC_STAGES-2:0], tck};
      tms_sync_q <= {tms_sync_q[SYNC_STAGES-2:0], tms};
      tdi_sync_q <= {tdi_sync_q[SYNC_STAGES-2:0], tdi};
      tck_prev_q <= tck_s;
    end
  end

  assign tck_s = tck_sync_q[SYNC_STAGES-1];
  assign tms_s = tms_sync_q[SYNC_STAGES-1];
  assign tdi_s = tdi_sync_q[SYNC_STAGES-1];
  assign rise  = tck_s & ~tck_prev_q;
  assign fall  = ~tck_s & tck_prev_q;

`ifdef JTAG_TRST_EN
  logic [SYNC_STAGES-1:0] trst_sync_q;
  logic                   trst_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trst_sync_q <= '0;
    end else begin
      trst_sync_q <= {trst_sync_q[SYNC_STAGES-2:0], trst_n};
    end
  end

  assign trst_s = trst_sync_q[SYNC_STAGES-1];
`endif

  tap_state_e            state_q, state_d;
  logic [IR_LEN-1:0]     ir_q, ir_sr_q;
  logic [31:0]           id_sr_q;
  logic [USER_LEN-1:0]   user_sr_q, user_wr_data_q;
  logic                  byp_q, tdo_q, tdo_oe_q, user_wr_stb_q;
  logic                  is_idcode, is_user, dr_lsb;

  assign is_idcode = (ir_q == IrIdcode);
  assign is_user   = (ir_q == IrUser);

  always_comb begin
    dr_lsb = byp_q;
    if (is_idcode) begin
      dr_lsb = id_sr_q[0];
    end else if (is_user) begin
      dr_lsb = user_sr_q[0];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StTlr:     state_d = tms_s ? StTlr     : StRti;
      StRti:     state_d = tms_s ? StSelDr   : StRti;
      StSelDr:   state_d = tms_s ? StSelIr   : StCapDr;
      StCapDr:   state_d = tms_s ? StEx1Dr   : StShDr;
      StShDr:    state_d = tms_s ? StEx1Dr   : StShDr;
      StEx1Dr:   state_d = tms_s ? StUpdDr   : StPauseDr;
      StPauseDr: state_d = tms_s ? StEx2Dr   : StPauseDr;
      StEx2Dr:   state_d = tms_s ? StUpdDr   : StShDr;
      StUpdDr:   state_d = tms_s ? StSelDr   : StRti;
      StSelIr:   state_d = tms_s ? StTlr     : StCapIr;
      StCapIr:   state_d = tms_s ? StEx1Ir   : StShIr;
      StShIr:    state_d = tms_s ? StEx1Ir   : StShIr;
      StEx1Ir:   state_d = tms_s ? StUpdIr   : StPauseIr;
      StPauseIr: state_d = tms_s ? StEx2Ir   : StPauseIr;
      StEx2Ir:   state_d = tms_s ? StUpdIr   : StShIr;
      StUpdIr:   state_d = tms_s ? StSelIr   : StRti;
    endcase
  end

  // Register actions belong to the state being left on each rise; tdo follows on the fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StTlr;
      ir_q           <= IrIdcode;
      ir_sr_q        <= '0;
      id_sr_q        <= '0;
      user_sr_q      <= '0;
      byp_q          <= 1'b0;
      tdo_q          <= 1'b0;
      tdo_oe_q       <= 1'b0;
      user_wr_data_q <= '0;
      user_wr_stb_q  <= 1'b0;
    end else begin
      user_wr_stb_q <= 1'b0;
      if (rise) begin
        state_q <= state_d;
        case (state_q)
          StCapIr: ir_sr_q <= IrIdcode;
          StShIr:  ir_sr_q <= {tdi_s, ir_sr_q[IR_LEN-1:1]};
          StUpdIr: ir_q    <= ir_sr_q;
          StCapDr: begin
            if (is_idcode) begin
              id_sr_q <= IDCODE_VAL;
            end else if (is_user) begin
              user_sr_q <= user_rd_data;
            end else begin
              byp_q <= 1'b0;
            end
          end
          StShDr: begin
            if (is_idcode) begin
              id_sr_q <= {tdi_s, id_sr_q[31:1]};
            end else if (is_user) begin
              user_sr_q <= {tdi_s, user_sr_q[USER_LEN-1:1]};
            end else begin
              byp_q <= tdi_s;
            end
          end
          StUpdDr: begin
            if (is_user) begin
              user_wr_data_q <= user_sr_q;
              user_wr_stb_q  <= 1'b1;
            end
          end
          default: ;
        endcase
      end else if (fall) begin
        if (state_q == StShIr) begin
          tdo_q    <= ir_sr_q[0];
          tdo_oe_q <= 1'b1;
        end else if (state_q == StShDr) begin
          tdo_q    <= dr_lsb;
          tdo_oe_q <= 1'b1;
        end else begin
          tdo_q    <= 1'b0;
          tdo_oe_q <= 1'b0;
        end
      end
      if (state_q == StTlr) begin
        ir_q <= IrIdcode;
      end
`ifdef JTAG_TRST_EN
      if (!trst_s) begin
        state_q <= StTlr;
        ir_q    <= IrIdcode;
      end
`endif
    end
  end

  assign tdo          = tdo_q;
  assign tdo_oe       = tdo_oe_q;
  assign user_wr_data = user_wr_data_q;
  assign user_wr_stb  = user_wr_stb_q;
  assign tap_state    = state_q;

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Randomized bench for jtag_tap_responder: a host-side model predicts every scan as bit queues.
module tb_jtag_tap_responder;

  localparam int unsigned IrLen     = 4;
  localparam int unsigned UserLen   = 32;
  localparam logic [31:0] IdcodeVal = 32'h1485_A0DD;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         tck = 1'b0;
  logic         tms = 1'b0;
  logic         tdi = 1'b0;
  logic         tdo, tdo_oe, user_wr_stb;
  logic [31:0]  user_rd_data = '0;
  logic [31:0]  user_wr_data;
  logic [3:0]   tap_state;
`ifdef JTAG_TRST_EN
  logic         trst_n = 1'b1;
`endif

  jtag_tap_responder #(
    .IR_LEN     (IrLen),
    .IDCODE_VAL (IdcodeVal),
    .USER_LEN   (UserLen),
    .SYNC_STAGES(2)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tck         (tck),
    .tms         (tms),
    .tdi         (tdi),
`ifdef JTAG_TRST_EN
    .trst_n      (trst_n),
`endif
    .tdo         (tdo),
    .tdo_oe      (tdo_oe),
    .user_rd_data(user_rd_data),
    .user_wr_data(user_wr_data),
    .user_wr_stb (user_wr_stb),
    .tap_state   (tap_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Host-side view of the target.
  logic [IrLen-1:0] ir_model = IrLen'(1);
  logic [31:0]      user_wr_model = '0;
  int               exp_stb = 0;

  int   stb_cycles = 0;
  int   stb_wide = 0;
  logic stb_prev = 1'b0;

  always @(negedge clk) begin
    if (user_wr_stb) begin
      stb_cycles <= stb_cycles + 1;
      if (stb_prev) stb_wide <= stb_wide + 1;
    end
    stb_prev <= user_wr_stb;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full TCK period; returns tdo/tdo_oe as left by the falling edge.
  task automatic tck_cycle(input logic tms_v, input logic tdi_v,
                           output logic tdo_v, output logic oe_v);
    tms = tms_v;
    tdi = tdi_v;
    repeat (3) @(posedge clk);
    #2 tck = 1'b1;
    repeat (5) @(posedge clk);
    #2 tck = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    tdo_v = tdo;
    oe_v  = tdo_oe;
  endtask

  task automatic tms_step(input logic tms_v);
    logic a, b;
    tck_cycle(tms_v, 1'b0, a, b);
  endtask

  task automatic goto_tlr_rti();
    repeat (5) tms_step(1'b1);
    check_eq("tlr_state", 64'(tap_state), 64'hF);
    check_eq("tlr_oe", 64'(tdo_oe), 64'h0);
    ir_model = IrLen'(1);
    tms_step(1'b0);
    check_eq("rti_state", 64'(tap_state), 64'hC);
  endtask

  // Enter the shift state (already past Select), shift n bits of din, return tdo/oe streams.
  task automatic shift_bits(input int n, input logic [63:0] din,
                            output logic [63:0] got_tdo, output logic [63:0] got_oe);
    logic t, o;
    got_tdo = '0;
    got_oe  = '0;
    tck_cycle(1'b0, 1'b0, t, o);
    got_tdo[0] = t;
    got_oe[0]  = o;
    for (int i = 0; i < n; i++) begin
      tck_cycle(i == n - 1, din[i], t, o);
      got_tdo[i+1] = t;
      got_oe[i+1]  = o;
    end
  endtask

  task automatic scan_ir(input logic [IrLen-1:0] val);
    logic [63:0] got_tdo, got_oe;
    tms_step(1'b1);
    tms_step(1'b1);
    tms_step(1'b0);
    shift_bits(IrLen, 64'(val), got_tdo, got_oe);
    check_eq("ir_tdo", got_tdo, 64'h1);
    check_eq("ir_oe", got_oe, (64'd1 << IrLen) - 64'd1);
    tms_step(1'b1);
    tms_step(1'b0);
    ir_model = val;
  endtask

  task automatic scan_dr(input int n, input logic [63:0] din);
    logic [63:0] got_tdo, got_oe, exp_tdo;
    logic [31:0] cap;
    logic [31:0] packed_q;
    int          len;
    bit          q[$];
    bit          is_user;
    is_user = (ir_model == IrLen'(2));
    if (ir_model == IrLen'(1)) begin
      len = 32;
      cap = IdcodeVal;
    end else if (is_user) begin
      len = UserLen;
      cap = user_rd_data;
    end else begin
      len = 1;
      cap = '0;
    end
    for (int k = 0; k < len; k++) q.push_back(cap[k]);
    exp_tdo = '0;
    for (int i = 0; i < n; i++) begin
      exp_tdo[i] = q[0];
      void'(q.pop_front());
      q.push_back(din[i]);
    end
    if (is_user) begin
      packed_q = '0;
      for (int k = 0; k < len; k++) packed_q[k] = q[k];
      user_wr_model = packed_q;
      exp_stb++;
    end
    tms_step(1'b1);
    tms_step(1'b0);
    shift_bits(n, din, got_tdo, got_oe);
    check_eq("dr_tdo", got_tdo, exp_tdo);
    check_eq("dr_oe", got_oe, (64'd1 << n) - 64'd1);
    tms_step(1'b1);
    tms_step(1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("dr_rti", 64'(tap_state), 64'hC);
    check_eq("stb_count", 64'(stb_cycles), 64'(exp_stb));
    check_eq("user_wr_data", 64'(user_wr_data), 64'(user_wr_model));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] got_tdo, got_oe;
    logic [IrLen-1:0] ir_v;
    logic [IrLen-1:0] dir_tab [4];
    dir_tab[0] = 4'hF;
    dir_tab[1] = 4'h1;
    dir_tab[2] = 4'h2;
    dir_tab[3] = 4'h7;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_state", 64'(tap_state), 64'hF);
    check_eq("rst_tdo", 64'(tdo), 64'h0);
    check_eq("rst_oe", 64'(tdo_oe), 64'h0);
    check_eq("rst_stb", 64'(user_wr_stb), 64'h0);
    check_eq("rst_wr_data", 64'(user_wr_data), 64'h0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    goto_tlr_rti();
    check_eq("no_stb", 64'(stb_cycles), 64'h0);

    scan_dr(32, 64'h0);
    scan_ir(4'hF);
    scan_dr(3, 64'h5);
    user_rd_data = 32'hDEAD_BEEF;
    scan_ir(4'h2);
    scan_dr(32, 64'hA5A5_1234);
    scan_ir(4'h7);
    scan_dr(5, 64'h1B);

    for (int it = 0; it < 18; it++) begin
      ir_v = (it < 4) ? dir_tab[it] : IrLen'($urandom_range(0, 15));
      user_rd_data = $urandom;
      if ($urandom_range(0, 5) == 0) goto_tlr_rti();
      scan_ir(ir_v);
      scan_dr(int'($urandom_range(1, 40)), {$urandom, $urandom});
    end
    check_eq("stb_width", 64'(stb_wide), 64'h0);

    // Reset in the middle of a USER scan.
    user_rd_data = $urandom;
    scan_ir(4'h2);
    tms_step(1'b1);
    tms_step(1'b0);
    shift_bits(10, {$urandom, $urandom}, got_tdo, got_oe);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_tdo", 64'(tdo), 64'h0);
    check_eq("midrst_oe", 64'(tdo_oe), 64'h0);
    check_eq("midrst_state", 64'(tap_state), 64'hF);
    check_eq("midrst_wr_data", 64'(user_wr_data), 64'h0);
    user_wr_model = '0;
    tms = 1'b0;
    repeat (3) @(posedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    goto_tlr_rti();
    scan_dr(32, 64'h0);
    check_eq("stb_width_end", 64'(stb_wide), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
